stack_ctrl: RTL and testbench
=============================

# stack_ctrl

Sequencer that owns the processor's data/return stack: accepts PUSH/POP/CALL/RET commands from the core over a valid/ready handshake, maintains the stack pointer and depth, and drives the data-memory port with the required write/read strobes. It replaces ad-hoc en/rw pulsing of the stack pointer with a single multi-cycle controller. It sits between the instruction decoder and the data memory.

## Interface
- AW, 8, memory address / stack pointer width
- DW, 8, data word width
- DEPTH, 64, maximum number of stacked words
- SP_RESET, 8'hFF, stack pointer value after reset (empty stack)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets on the next rising clk)
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
- cmd_data  in  DW  PUSH word / CALL return PC
- cmd_flags  in  DW  CALL flags word
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DW  POP word / RET PC
- rsp_flags  out  DW  RET flags word (0 for other ops)
- rsp_err  out  1  command rejected (overflow/underflow), valid with rsp_valid
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe; mem_rdata valid the cycle after
- mem_rdata  in  DW  read data
- sp  out  AW  current stack pointer
- depth  out  AW  words currently stacked
- err_ovf, err_udf  out  1 each  sticky overflow/underflow flags

## Operation
- Descending stack; SP points at next free slot. Push: write at SP, SP<=SP-1. Pop: SP<=SP+1, read at SP+1.
- States: IDLE, WR_A, WR_B, RD_A, RD_WA, RD_B, RD_WB, DONE.
- IDLE: cmd_ready=1; on cmd_valid&cmd_ready latch op/data/flags. PUSH->WR_A; CALL->WR_A; POP->RD_A; RET->RD_A.
- WR_A: mem_we=1, mem_addr=SP, mem_wdata=data. CALL->WR_B, else DONE.
- WR_B: mem_we=1, mem_addr=SP, mem_wdata=flags -> DONE.
- RD_A: mem_re=1, mem_addr=SP+1 -> RD_WA. RD_WA: capture mem_rdata (POP -> rsp_data, RET -> rsp_flags); RET->RD_B, else DONE.
- RD_B: mem_re=1, mem_addr=SP+1 -> RD_WB. RD_WB: capture mem_rdata into rsp_data -> DONE.
- DONE: rsp_valid=1 for one cycle -> IDLE. rsp_data/rsp_flags hold until next accept.
- depth +1 per write, -1 per read; SP arithmetic modulo 2^AW.
- mem_we, mem_re, rsp_valid are never asserted in the same cycle as each other.

## Timing
- Reset values: state IDLE, sp=SP_RESET, depth=0, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, err_ovf=0, err_udf=0.
- Accept at cycle 0; PUSH rsp_valid cycle 2; CALL 3; POP 3; RET 5; next accept one cycle after DONE.
- cmd_ready is low in every state except IDLE; cmd_* ignored while low.
- Reset low mid-command: strobes forced 0 in that cycle; next edge all registers return to reset values; partial CALL/RET is abandoned with no rsp_valid.
- Reset has priority over any command accepted in the same cycle.

## Configuration
- STACK_CTRL_GUARD_EN defined: at accept, PUSH/CALL with depth+k>DEPTH (k=1/2) or POP/RET with depth<k is rejected: no memory strobe, sp/depth unchanged, go directly to DONE with rsp_err=1; err_ovf or err_udf set, cleared only by reset.
- Undefined: no checks; rsp_err, err_ovf, err_udf tied 0; sp and depth wrap modulo 2^AW.

## Test plan
- Reset then PUSH 8'hA5 -> cycle 1 mem_we=1, mem_addr=8'hFF, mem_wdata=8'hA5; cycle 2 rsp_valid=1; sp=8'hFE, depth=1.
- PUSH 8'h11, PUSH 8'h22, POP, POP (memory model 1-cycle read) -> rsp_data 8'h22 then 8'h11; sp=8'hFF, depth=0.
- CALL data=8'h40 flags=8'h03, then RET -> writes FF=40, FE=03; RET reads FE then FF; rsp_flags=8'h03, rsp_data=8'h40, rsp_valid at cycle 5 after accept.
- Guard on, POP at depth 0 -> rsp_valid with rsp_err=1 at cycle 1, no mem_re, err_udf=1, sp=8'hFF; 64 PUSHes then PUSH -> rsp_err=1, err_ovf=1, depth=64.
- Guard off, POP at reset -> mem_addr=8'h00, sp=8'h00, depth=8'hFF, rsp_err=0.
- CALL accepted, rst=0 in WR_B cycle -> mem_we=0 that cycle, next cycle sp=8'hFF, depth=0, cmd_ready=1, no rsp_valid.

Source files
------------

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - data/return stack sequencer with valid/ready command port and memory strobes (optional guard: STACK_CTRL_GUARD_EN)
module stack_ctrl #(
    parameter int             AW       = 8,
    parameter int             DW       = 8,
    parameter int             DEPTH    = 64,
    parameter logic [AW-1:0]  SP_RESET = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    input  logic [DW-1:0] cmd_flags,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [DW-1:0] rsp_flags,
    output logic          rsp_err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] sp,
    output logic [AW-1:0] depth,
    output logic          err_ovf,
    output logic          err_udf
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_WR_B, S_RD_A, S_RD_WA, S_RD_B, S_RD_WB, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_op;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_flags;
    logic [AW-1:0] r_sp;
    logic [AW-1:0] r_depth;
    logic [DW-1:0] r_rsp_data;
    logic [DW-1:0] r_rsp_flags;
    logic          w_accept;
    logic          w_reject;

    assign w_accept = cmd_valid && (r_state == S_IDLE);

`ifdef STACK_CTRL_GUARD_EN
    localparam logic [AW:0] LP_PUSH_MAX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] LP_CALL_MAX = (AW+1)'(DEPTH - 2);

    logic r_rsp_err;
    logic r_err_ovf;
    logic r_err_udf;

    // Capacity check on the command being offered: overflow for writes, underflow for reads
    always_comb begin
        w_reject = 1'b0;
        case (cmd_op)
            OP_PUSH: w_reject = {1'b0, r_depth} > LP_PUSH_MAX;
            OP_CALL: w_reject = {1'b0, r_depth} > LP_CALL_MAX;
            OP_POP:  w_reject = r_depth == '0;
            OP_RET:  w_reject = r_depth < AW'(2);
            default: w_reject = 1'b0;
        endcase
    end

    // Error response per command plus sticky flags that only reset clears
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp_err <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err <= w_reject;
            if (w_reject && !cmd_op[0]) r_err_ovf <= 1'b1;
            if (w_reject &&  cmd_op[0]) r_err_udf <= 1'b1;
        end
    end

    assign rsp_err = r_rsp_err;
    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`else
    assign w_reject = 1'b0;
    assign rsp_err  = 1'b0;
    assign err_ovf  = 1'b0;
    assign err_udf  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state sequencing: writes go one or two slots down, reads come back up
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (w_reject)                                  w_next = S_DONE;
                    else if (cmd_op == OP_PUSH || cmd_op == OP_CALL) w_next = S_WR_A;
                    else                                           w_next = S_RD_A;
                end
            end
            S_WR_A:  w_next = (r_op == OP_CALL) ? S_WR_B : S_DONE;
            S_WR_B:  w_next = S_DONE;
            S_RD_A:  w_next = S_RD_WA;
            S_RD_WA: w_next = (r_op == OP_RET) ? S_RD_B : S_DONE;
            S_RD_B:  w_next = S_RD_WB;
            S_RD_WB: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, stack pointer/depth bookkeeping and read-data capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op        <= OP_PUSH;
            r_data      <= '0;
            r_flags     <= '0;
            r_sp        <= SP_RESET;
            r_depth     <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op        <= cmd_op;
                        r_data      <= cmd_data;
                        r_flags     <= cmd_flags;
                        r_rsp_data  <= '0;
                        r_rsp_flags <= '0;
                    end
                end
                S_WR_A, S_WR_B: begin
                    r_sp    <= r_sp - AW'(1);
                    r_depth <= r_depth + AW'(1);
                end
                S_RD_A, S_RD_B: begin
                    r_sp    <= r_sp + AW'(1);
                    r_depth <= r_depth - AW'(1);
                end
                S_RD_WA: begin
                    if (r_op == OP_RET) r_rsp_flags <= mem_rdata;
                    else                r_rsp_data  <= mem_rdata;
                end
                S_RD_WB: r_rsp_data <= mem_rdata;
                default: ;
            endcase
        end
    end

    // Memory port and handshake decode; strobes are killed while reset is held
    always_comb begin
        cmd_ready = (r_state == S_IDLE);
        rsp_valid = rst && (r_state == S_DONE);
        mem_we    = rst && (r_state == S_WR_A || r_state == S_WR_B);
        mem_re    = rst && (r_state == S_RD_A || r_state == S_RD_B);
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            S_WR_A: begin mem_addr = r_sp; mem_wdata = r_data;  end
            S_WR_B: begin mem_addr = r_sp; mem_wdata = r_flags; end
            S_RD_A, S_RD_B: mem_addr = r_sp + AW'(1);
            default: ;
        endcase
    end

    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign sp        = r_sp;
    assign depth     = r_depth;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - directed self-checking bench for stack_ctrl
module tb_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] cmd_flags = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic [7:0] rsp_flags;
    logic       rsp_err;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       mem_re;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] sp;
    logic [7:0] depth;
    logic       err_ovf;
    logic       err_udf;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] mem [256];

    stack_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_flags(cmd_flags),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .sp(sp), .depth(depth),
        .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    // Memory model: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Issue one command from IDLE; return at the rsp_valid cycle (bounded)
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic [7:0] f,
                          output int lat, output bit saw_we, output bit saw_re);
        cmd_op = op; cmd_data = d; cmd_flags = f; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lat = 1; saw_we = 1'b0; saw_re = 1'b0;
        while (!rsp_valid && lat < 12) begin
            saw_we |= mem_we;
            saw_re |= mem_re;
            tick();
            lat++;
        end
    endtask

    int lat;
    bit swe, sre, seen;

    initial begin
        do_reset();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_sp", sp, 8'hFF);
        chk("rst_depth", depth, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_udf", err_udf, 0);

`ifdef STACK_CTRL_GUARD_EN
        do_cmd(2'b01, 8'h00, 8'h00, lat, swe, sre);
        chk("udf_lat", lat, 1);
        chk("udf_rsp_err", rsp_err, 1);
        chk("udf_no_re", sre, 0);
        chk("udf_flag", err_udf, 1);
        chk("udf_sp", sp, 8'hFF);
        chk("udf_depth", depth, 0);
        tick();
        for (int i = 0; i < 64; i++) begin
            do_cmd(2'b00, 8'(i), 8'h00, lat, swe, sre);
            chk("fill_lat", lat, 2);
            tick();
        end
        chk("fill_depth", depth, 64);
        do_cmd(2'b00, 8'hEE, 8'h00, lat, swe, sre);
        chk("ovf_lat", lat, 1);
        chk("ovf_rsp_err", rsp_err, 1);
        chk("ovf_no_we", swe, 0);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_udf_sticky", err_udf, 1);
        chk("ovf_depth", depth, 64);
        chk("ovf_sp", sp, 8'hBF);
        tick();
        do_reset();
        chk("rst2_err_ovf", err_ovf, 0);
        chk("rst2_err_udf", err_udf, 0);
`else
        // Unguarded POP at reset wraps the pointer and depth
        cmd_op = 2'b01; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("wrap_mem_re", mem_re, 1);
        chk("wrap_mem_addr", mem_addr, 8'h00);
        tick();
        tick();
        chk("wrap_rsp_valid", rsp_valid, 1);
        chk("wrap_sp", sp, 8'h00);
        chk("wrap_depth", depth, 8'hFF);
        chk("wrap_rsp_err", rsp_err, 0);
        tick();
        do_reset();
`endif

        // PUSH A5 with cycle-exact strobes
        cmd_op = 2'b00; cmd_data = 8'hA5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        chk("push_ready_low", cmd_ready, 0);
        chk("push_we", mem_we, 1);
        chk("push_re", mem_re, 0);
        chk("push_addr", mem_addr, 8'hFF);
        chk("push_wdata", mem_wdata, 8'hA5);
        chk("push_no_rsp_c1", rsp_valid, 0);
        tick();
        chk("push_rsp_valid", rsp_valid, 1);
        chk("push_we_off", mem_we, 0);
        chk("push_sp", sp, 8'hFE);
        chk("push_depth", depth, 1);
        tick();
        chk("push_back_idle", cmd_ready, 1);
        chk("push_rsp_pulse", rsp_valid, 0);
        chk("mem_FF_A5", mem[8'hFF], 8'hA5);

        // LIFO order
        do_reset();
        do_cmd(2'b00, 8'h11, 8'h00, lat, swe, sre); tick();
        do_cmd(2'b00, 8'h22, 8'h00, lat, swe, sre); tick();
        do_cmd(2'b01, 8'h00, 8'h00, lat, swe, sre);
        chk("pop1_lat", lat, 3);
        chk("pop1_data", rsp_data, 8'h22);
        chk("pop1_flags", rsp_flags, 8'h00);
        tick();
        chk("pop1_hold", rsp_data, 8'h22);
        do_cmd(2'b01, 8'h00, 8'h00, lat, swe, sre);
        chk("pop2_data", rsp_data, 8'h11);
        chk("pop2_sp", sp, 8'hFF);
        chk("pop2_depth", depth, 0);
        tick();

        // CALL then RET
        do_cmd(2'b10, 8'h40, 8'h03, lat, swe, sre);
        chk("call_lat", lat, 3);
        chk("call_sp", sp, 8'hFD);
        chk("call_depth", depth, 2);
        tick();
        chk("call_mem_FF", mem[8'hFF], 8'h40);
        chk("call_mem_FE", mem[8'hFE], 8'h03);
        do_cmd(2'b11, 8'h00, 8'h00, lat, swe, sre);
        chk("ret_lat", lat, 5);
        chk("ret_flags", rsp_flags, 8'h03);
        chk("ret_data", rsp_data, 8'h40);
        chk("ret_err", rsp_err, 0);
        chk("ret_sp", sp, 8'hFF);
        chk("ret_depth", depth, 0);
        tick();

        // Reset in the middle of a CALL
        cmd_op = 2'b10; cmd_data = 8'h55; cmd_flags = 8'h66; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("abort_wr_b_we", mem_we, 1);
        chk("abort_wr_b_wdata", mem_wdata, 8'h66);
        rst = 1'b0;
        #1;
        chk("abort_we_forced", mem_we, 0);
        tick();
        rst = 1'b1;
        chk("abort_sp", sp, 8'hFF);
        chk("abort_depth", depth, 0);
        chk("abort_ready", cmd_ready, 1);
        seen = rsp_valid;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen |= rsp_valid;
        end
        chk("abort_no_rsp", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
